pokey_serout_ctrl: RTL and testbench

Transmit sequencer for the POKEY serial output port. It owns the SEROUT holding register and drives Load/Shift to the external DATA_BITS-long shift-cell chain, whose cells register on posedge clk when enp=1. It frames each byte as a start bit, then DATA_BITS data bits LSB first, then a stop bit, paced by the baud tick from the channel-4 timer. It also produces the serial-output-needed and transmission-done status for the IRQ block.

---
 rtl/pokey_serout_if.sv | 22 ++
 rtl/pokey_serout_ctrl.sv | 101 ++++++++++
 tb/tb_pokey_serout_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pokey_serout_if.sv
// POKEY serial-out bus: CPU SEROUT write port plus shift-chain controls.
// master: CPU/cell side; slave: the sequencer.
interface pokey_serout_if #(
  parameter int DATA_BITS = 8
);
  logic                 serout_wr;
  logic [DATA_BITS-1:0] serout_data;
  logic [DATA_BITS-1:0] sr_din;
  logic                 sr_load;
  logic                 sr_shift;
  logic                 sr_lsb;

  modport master (
    output serout_wr, serout_data, sr_lsb,
    input  sr_din, sr_load, sr_shift
  );

  modport slave (
    input  serout_wr, serout_data, sr_lsb,
    output sr_din, sr_load, sr_shift
  );
endinterface

// File: rtl/pokey_serout_ctrl.sv
// POKEY serial transmit sequencer: start, DATA_BITS LSB-first, stop.
// Ports: clk, rst_n, enp, baud_tick, brk, bus (slave), sout, odn_p, xmt_done.
module pokey_serout_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enp,
  input  logic           baud_tick,
  input  logic           brk,
  pokey_serout_if.slave  bus,
  output logic           sout,
  output logic           odn_p,
  output logic           xmt_done
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [CW-1:0]        bitcnt;
  logic                 tick;
  logic                 last;
  logic                 xfer;
  logic                 line;

  assign tick = enp & baud_tick;
  assign last = (bitcnt == LAST);

  // Holding register moves into the cells from IDLE or straight out of STOP
  assign xfer = tick & hold_full &
                ((state == IDLE) | (state == STOP));

  assign bus.sr_load  = xfer;
  assign bus.sr_shift = tick & (state == DATA) & ~last;
  assign bus.sr_din   = hold_data;

  assign xmt_done = (state == IDLE) & ~hold_full;

  always_comb begin
    line = 1'b1;
    unique case (state)
      START:   line = 1'b0;
      DATA:    line = bus.sr_lsb;
      default: line = 1'b1;
    endcase
  end

  assign sout = line & ~brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      bitcnt    <= '0;
      odn_p     <= 1'b0;
    end else begin
      // one-clk pulse; xfer already implies enp
      odn_p <= xfer;

      // a write on the transfer edge keeps the new byte pending
      if (enp && bus.serout_wr) begin
        hold_data <= bus.serout_data;
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end

      if (tick) begin
        unique case (state)
          IDLE: begin
            if (hold_full) state <= START;
          end
          START: begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            if (last) state <= STOP;
            else      bitcnt <= bitcnt + CW'(1);
          end
          STOP: begin
            state <= hold_full ? START : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pokey_serout_ctrl.sv
// Directed bench for pokey_serout_ctrl with a behavioural shift chain.
// Ports: none (top-level bench).
module tb_pokey_serout_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enp = 1'b0;
  logic baud_tick = 1'b0;
  logic brk = 1'b0;
  logic sout;
  logic odn_p;
  logic xmt_done;

  int checks = 0;
  int errors = 0;
  int gap = 2;
  int n_load = 0;
  int n_shift = 0;
  int n_odn = 0;
  int n_late = 0;
  int n_both = 0;
  logic s_sout;
  logic s_done;
  logic [7:0] q = '0;

  pokey_serout_if #(.DATA_BITS(8)) bus ();

  pokey_serout_ctrl #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enp       (enp),
    .baud_tick (baud_tick),
    .brk       (brk),
    .bus       (bus.slave),
    .sout      (sout),
    .odn_p     (odn_p),
    .xmt_done  (xmt_done)
  );

  always #5 clk = ~clk;

  // external shift-cell chain
  assign bus.sr_lsb = q[0];
  always @(posedge clk) begin
    if (enp) begin
      if (bus.sr_load)       q <= bus.sr_din;
      else if (bus.sr_shift) q <= {1'b0, q[7:1]};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic eb(input logic [7:0] d, input int i);
    if (i == 0) return 1'b1;
    if (i == 1) return 1'b0;
    if (i <= 9) return d[i-2];
    return 1'b1;
  endfunction

  task automatic clr();
    n_load = 0;
    n_shift = 0;
    n_odn = 0;
  endtask

  // one slow cycle: a gated clk (enp=0, tick still high) then an enp clk
  task automatic slow(input logic t, input logic w, input logic [7:0] d);
    @(negedge clk);
    enp = 1'b0;
    baud_tick = t;
    bus.serout_wr = 1'b0;
    #1;
    if (odn_p) n_odn++;
    @(negedge clk);
    enp = 1'b1;
    baud_tick = t;
    bus.serout_wr = w;
    bus.serout_data = d;
    #1;
    s_sout = sout;
    s_done = xmt_done;
    if (odn_p) n_late++;
    if (bus.sr_load) n_load++;
    if (bus.sr_shift) n_shift++;
    if (bus.sr_load && bus.sr_shift) n_both++;
    @(posedge clk);
    #1;
    enp = 1'b0;
    baud_tick = 1'b0;
    bus.serout_wr = 1'b0;
  endtask

  task automatic tck(input string tag, input logic exp,
                     input logic w, input logic [7:0] d);
    for (int k = 1; k < gap; k++) slow(1'b0, 1'b0, 8'h00);
    slow(1'b1, w, d);
    chk(tag, s_sout, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.serout_wr = 1'b0;
    bus.serout_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sout", sout, 1);
    chk("rst_done", xmt_done, 1);
    chk("rst_load", bus.sr_load, 0);
    chk("rst_shift", bus.sr_shift, 0);
    chk("rst_odn", odn_p, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic frame, tick every 4 enp cycles
    gap = 4;
    clr();
    slow(1'b0, 1'b1, 8'hA5);
    slow(1'b0, 1'b0, 8'h00);
    chk("a5_done_wr", s_done, 0);
    for (int i = 0; i <= 10; i++) begin
      tck("a5_sout", eb(8'hA5, i), 1'b0, 8'h00);
      chk("a5_done", s_done, 0);
    end
    slow(1'b0, 1'b0, 8'h00);
    chk("a5_done_end", s_done, 1);
    chk("a5_load", n_load, 1);
    chk("a5_shift", n_shift, 7);
    chk("a5_odn", n_odn, 1);

    // back-to-back frames, incl. write on the transfer edge
    gap = 2;
    clr();
    slow(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i <= 10; i++) begin
      tck("3c_sout", eb(8'h3C, i), (i == 4), 8'hC3);
      chk("3c_done", s_done, 0);
    end
    chk("3c_odn2", n_load, 2);
    for (int i = 1; i <= 10; i++) begin
      tck("c3_sout", eb(8'hC3, i), (i == 4) || (i == 10),
          (i == 10) ? 8'h55 : 8'hFF);
      chk("c3_done", s_done, 0);
    end
    #1;
    chk("ff_hold_full", dut.hold_full, 1);
    for (int i = 1; i <= 10; i++) begin
      tck("ff_sout", eb(8'hFF, i), 1'b0, 8'h00);
      chk("ff_done", s_done, 0);
    end
    for (int i = 1; i <= 10; i++)
      tck("55_sout", eb(8'h55, i), 1'b0, 8'h00);
    slow(1'b0, 1'b0, 8'h00);
    chk("b2b_done_end", s_done, 1);
    chk("b2b_load", n_load, 4);
    chk("b2b_shift", n_shift, 28);
    chk("b2b_odn", n_odn, 4);

    // overwrite before first tick
    clr();
    slow(1'b0, 1'b1, 8'h11);
    slow(1'b0, 1'b1, 8'h22);
    for (int i = 0; i <= 10; i++)
      tck("22_sout", eb(8'h22, i), 1'b0, 8'h00);
    slow(1'b0, 1'b0, 8'h00);
    chk("ovr_load", n_load, 1);
    chk("ovr_odn", n_odn, 1);
    chk("ovr_done", s_done, 1);

    // break mid-frame
    clr();
    slow(1'b0, 1'b1, 8'h96);
    for (int i = 0; i <= 10; i++) begin
      brk = (i >= 4) && (i <= 6);
      tck("brk_sout", brk ? 1'b0 : eb(8'h96, i), 1'b0, 8'h00);
    end
    brk = 1'b0;
    slow(1'b0, 1'b0, 8'h00);
    chk("brk_shift", n_shift, 7);
    chk("brk_done", s_done, 1);

    // reset during data bit 4
    clr();
    slow(1'b0, 1'b1, 8'hB7);
    for (int i = 0; i <= 5; i++)
      tck("b7_sout", eb(8'hB7, i), (i == 3), 8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_sout", sout, 1);
    chk("mr_done", xmt_done, 1);
    chk("mr_odn", odn_p, 0);
    n_shift = 0;
    repeat (3) slow(1'b1, 1'b0, 8'h00);
    chk("mr_noshift", n_shift, 0);
    @(negedge clk);
    rst_n = 1'b1;
    slow(1'b1, 1'b0, 8'h00);
    chk("mr_idle_done", s_done, 1);
    clr();
    slow(1'b0, 1'b1, 8'h4E);
    for (int i = 0; i <= 10; i++)
      tck("4e_sout", eb(8'h4E, i), 1'b0, 8'h00);
    slow(1'b0, 1'b0, 8'h00);
    chk("4e_shift", n_shift, 7);
    chk("4e_odn", n_odn, 1);
    chk("4e_done", s_done, 1);

    chk("odn_one_clk", n_late, 0);
    chk("load_shift_excl", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
